// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush controls exchanged between the pipeline datapath
// and pipeline_ctrl.
interface pipeline_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] ex_rd;
    logic             ex_is_load;
    logic             ex_reg_write;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic [1:0]       state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_is_load, ex_reg_write, branch_taken,
               mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               state, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_is_load, ex_reg_write, branch_taken,
               mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               state, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory freezes, taken
// branches and load-use hazards into PC / pipeline-register enables.
module pipeline_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);
    localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic [REG_W-1:0]  id_rs1, id_rs2, ex_rd;
    logic              rs1_hit, rs2_hit;
    logic              memstall, loaduse;
    logic              pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;

    assign id_rs1 = bus.id_rs1;
    assign id_rs2 = bus.id_rs2;
    assign ex_rd  = bus.ex_rd;

    // ex_rd != 0 also guarantees that an rs index of 0 never matches.
    assign rs1_hit  = bus.id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = bus.id_rs2_used && (id_rs2 == ex_rd);
    assign loaduse  = bus.ex_is_load && bus.ex_reg_write && (ex_rd != '0)
                      && (rs1_hit || rs2_hit);
    assign memstall = bus.mem_req && !bus.mem_ready;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        if (rst || memstall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (loaduse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (memstall) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (memstall) begin
                    if (wait_q < WAIT_MAX) begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    // Either completed (mem_ready) or cancelled (mem_req dropped).
                    state_d = RUN;
                    wait_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase

        timeout_d = timeout_q || (memstall && (wait_d == WAIT_MAX));

        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_en      = idex_en;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_en     = exmem_en;
    assign bus.state        = state_q;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage integer pipeline.
- Drives the enable, flush and bubble controls of the PC, the IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles three hazard classes: load-use hazards, taken branches resolved in EX, and multi-cycle memory accesses.
- Sits beside the pipeline registers. Consumes register indices and tags from ID and EX, and the handshake from the data-memory port.

Parameters:
- REG_W, 5, width of a register index; register 0 is hardwired zero.
- MEM_TIMEOUT, 64, memory-wait cycles before mem_timeout is raised; must be ≥1.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- id_rs1  input  REG_W  rs1 index of the instruction in ID.
- id_rs2  input  REG_W  rs2 index of the instruction in ID.
- id_rs1_used  input  1  ID instruction reads rs1.
- id_rs2_used  input  1  ID instruction reads rs2.
- ex_rd  input  REG_W  destination of the instruction in EX.
- ex_is_load  input  1  EX instruction is a load.
- ex_reg_write  input  1  EX instruction writes ex_rd.
- branch_taken  input  1  branch/jump in EX resolved taken.
- mem_req  input  1  MEM stage has an access outstanding this cycle.
- mem_ready  input  1  memory completes the access this cycle.
- pc_en  output  1  PC update enable.
- ifid_en  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID loads NOP.
- idex_en  output  1  ID/EX load enable.
- idex_bubble  output  1  ID/EX loads NOP (write_alu_result_tag=0, rd=0).
- exmem_en  output  1  EX/MEM load enable.
- state  output  2  FSM state: 0 RUN, 1 MEM_WAIT.
- mem_timeout  output  1  sticky: a memory wait exceeded MEM_TIMEOUT.
- stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0.
  - While rst is held: all enables=0, ifid_flush=0, idex_bubble=0.
- Control outputs are combinational from state and inputs, so they take effect on the same edge. State and counters update on posedge clk.
- Decoded conditions:
  - memstall = mem_req & ~mem_ready.
  - loaduse = ex_is_load & ex_reg_write & (ex_rd≠0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Priority, highest first: memstall > branch_taken > loaduse > normal.
- Freeze (memstall in either state):
  - pc_en=ifid_en=idex_en=exmem_en=0.
  - flush=bubble=0.
  - branch_taken and loaduse are ignored this cycle; they are re-evaluated once the pipeline is released.
- Branch (no memstall, branch_taken=1):
  - pc_en=1 (loads target), all enables=1.
  - ifid_flush=1, idex_bubble=1.
  - loaduse is ignored because the ID instruction is wrong-path.
- Load-use (no memstall, no branch, loaduse=1):
  - pc_en=0, ifid_en=0.
  - idex_en=1 with idex_bubble=1, exmem_en=1.
  - Exactly one bubble per hazard.
- Normal: all enables=1, flush=bubble=0.
- FSM transitions:
  - RUN→MEM_WAIT on memstall. The wait counter loads 1.
  - MEM_WAIT→RUN in the cycle mem_ready=1. That cycle is released: outputs follow the normal/branch/loaduse rules.
  - In MEM_WAIT with memstall, the wait counter increments, saturating at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, mem_timeout is set. It stays set until rst. The FSM remains in MEM_WAIT.
  - If mem_req drops without mem_ready while in MEM_WAIT, go to RUN and release; the access is treated as cancelled.
- stall_cycles increments on every clock edge where pc_en=0, saturating at 2^CNT_W−1. This includes both freeze and load-use cycles.
- Asserting rst mid-wait aborts immediately to RUN and clears mem_timeout and both counters.
- id_rs*=0 never creates a hazard.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_rs2_used=1 for 1 cycle → pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1 for exactly 1 cycle; stall_cycles 0→1. Repeat with ex_rd=0 → no stall.
- Branch + load-use in the same cycle: branch_taken=1 with a loaduse condition → pc_en=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → all enables 0 for 3 cycles, state=1 after the first edge, release and state=0 on the ready cycle; stall_cycles=3.
- Memory stall masking a branch: memstall with branch_taken=1 → no flush. On the release cycle, with branch_taken still 1 → ifid_flush=1, idex_bubble=1.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles → mem_timeout=1 after the 4th wait cycle and stays 1 after mem_ready. Then rst pulse mid-cycle → state=0, mem_timeout=0, stall_cycles=0 without a clock edge.
- Saturation: CNT_W=4, 20 load-use cycles → stall_cycles stops at 15.
